vga_write: RTL and testbench

- Display-side consumer of the frame memory arbiter.
- Requests packed two-pixel memory words via vga_flag/done_vga and absorbs the fixed read latency with a credit-checked word FIFO.
- Unpacks each word into two pixels timed to the external VGA raster counters; frame_flag re-aligns fetching to the new display image.
- Sits between memory_interface (vga_flag, done_vga, vga_pixel) and the top-level VGA output register/DAC.

---
 rtl/vga_write.sv | 145 ++++++++++++++
 tb/tb_vga_write.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_write.sv
// Display-side frame memory reader: requests packed two-pixel words, absorbs the
// fixed read latency in a credit-checked FIFO and unpacks words onto the raster.
module vga_write #(
    parameter int MEM_W      = 36,
    parameter int PIX_W      = 18,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_flag,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    input  logic             blank,
    input  logic             done_vga,
    input  logic [MEM_W-1:0] vga_pixel,
    output logic             vga_flag,
    output logic [PIX_W-1:0] pixel_out,
    output logic             underflow,
    output logic             underflow_sticky
);

    localparam int WORDS = IMG_W * IMG_H / 2;
    localparam int WC_W  = $clog2(WORDS) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [WC_W-1:0] LAST_WC = WC_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              r_state;
    logic [READ_LAT-1:0] r_inflight;
    logic [CNT_W-1:0]    r_fifo_cnt;
    logic [CNT_W-1:0]    r_discard;
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [MEM_W-1:0]    r_mem [FIFO_DEPTH];
    logic [WC_W-1:0]     r_word_cnt;
    logic                r_even_ok;

    logic [CNT_W-1:0]    w_infl_cnt;
    logic [CNT_W:0]      w_credit;
    logic                w_req;
    logic                w_grant;
    logic                w_ret;
    logic                w_push;
    logic                w_pop;
    logic                w_active;
    logic                w_disp;
    logic                w_empty;
    logic [MEM_W-1:0]    w_head;

    always_comb begin
        w_infl_cnt = '0;
        for (int unsigned i = 0; i < READ_LAT; i++) begin
            w_infl_cnt = w_infl_cnt + CNT_W'(r_inflight[i]);
        end
    end

    assign w_credit = {1'b0, r_fifo_cnt} + {1'b0, w_infl_cnt};
    assign w_req    = (r_state == RUN) && (w_credit < DEPTH_V);
    assign w_grant  = w_req && done_vga;
    assign w_ret    = r_inflight[READ_LAT-1];
    assign w_empty  = (r_fifo_cnt == '0);
    assign w_head   = r_mem[r_rptr];
    assign w_active = !blank && (hcount < 11'(IMG_W)) && (vcount < 10'(IMG_H));
    assign w_disp   = w_active && (r_state != IDLE);
    // A word is only popped once its upper pixel was shown on the preceding even column.
    assign w_pop    = w_disp && hcount[0] && r_even_ok && !w_empty && !frame_flag;
    assign w_push   = w_ret && (r_discard == '0) && !frame_flag;
    assign vga_flag = w_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_inflight       <= '0;
            r_fifo_cnt       <= '0;
            r_discard        <= '0;
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_word_cnt       <= '0;
            r_even_ok        <= 1'b0;
            pixel_out        <= '0;
            underflow        <= 1'b0;
            underflow_sticky <= 1'b0;
        end else begin
            r_inflight <= (r_inflight << 1) | READ_LAT'(w_grant);

            if (frame_flag) begin
                // The return landing this cycle is dropped by the flush itself,
                // so only the words still in flight afterwards need discarding.
                r_state          <= RUN;
                r_word_cnt       <= WC_W'(w_grant);
                r_discard        <= w_infl_cnt - CNT_W'(w_ret);
                r_fifo_cnt       <= '0;
                r_wptr           <= '0;
                r_rptr           <= '0;
                r_even_ok        <= 1'b0;
                underflow_sticky <= 1'b0;
            end else begin
                if (w_grant) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
                if ((r_state == RUN) && w_grant && (r_word_cnt == LAST_WC)) begin
                    r_state <= DONE;
                end
                if (w_ret && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
                r_even_ok  <= w_disp && !hcount[0] && !w_empty;
                if (w_disp && w_empty) begin
                    underflow_sticky <= 1'b1;
                end
            end

            underflow <= w_disp && w_empty;
            if (!w_disp || w_empty) begin
                pixel_out <= '0;
            end else if (!hcount[0]) begin
                pixel_out <= w_head[MEM_W-1:PIX_W];
            end else if (r_even_ok) begin
                pixel_out <= w_head[PIX_W-1:0];
            end else begin
                pixel_out <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= vga_pixel;
        end
    end

endmodule

// File: tb/tb_vga_write.sv
// Scoreboard bench for vga_write: stimulus queues expected values tagged with the
// cycle they must appear; a negedge monitor pops and compares them.
module tb_vga_write;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_flag = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        blank = 1'b1;
    logic        done_vga = 1'b0;
    logic [35:0] vga_pixel = '0;
    logic        vga_flag;
    logic [17:0] pixel_out;
    logic        underflow;
    logic        underflow_sticky;

    logic        ff2 = 1'b0;
    logic        dv2 = 1'b1;
    logic        blank2 = 1'b1;
    logic [10:0] hc2 = '0;
    logic [9:0]  vc2 = '0;
    logic [35:0] px2 = '0;
    logic        flag2;
    logic [17:0] pix2;
    logic        uf2;
    logic        st2;

    vga_write #(.MEM_W(36), .PIX_W(18), .IMG_W(640), .IMG_H(480), .READ_LAT(2), .FIFO_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag), .hcount(hcount), .vcount(vcount),
        .blank(blank), .done_vga(done_vga), .vga_pixel(vga_pixel), .vga_flag(vga_flag),
        .pixel_out(pixel_out), .underflow(underflow), .underflow_sticky(underflow_sticky)
    );

    vga_write #(.MEM_W(36), .PIX_W(18), .IMG_W(4), .IMG_H(2), .READ_LAT(2), .FIFO_DEPTH(8)) dut_small (
        .clock(clock), .reset(reset), .frame_flag(ff2), .hcount(hc2), .vcount(vc2),
        .blank(blank2), .done_vga(dv2), .vga_pixel(px2), .vga_flag(flag2),
        .pixel_out(pix2), .underflow(uf2), .underflow_sticky(st2)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct packed {
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   timeout_hit = 1'b0;

    // Memory model: data for the grant seen at a posedge appears two cycles later.
    int          gcnt = 0;
    int          gbase = 0;
    logic [35:0] d1 = 36'hA5A5A5A5A;
    logic        m_g;
    int          m_idx;
    always @(posedge clock) begin
        m_g   = vga_flag && done_vga;
        m_idx = gcnt - gbase;
        if (m_g) gcnt++;
        #2;
        vga_pixel = d1;
        d1 = m_g ? {18'(2 * m_idx), 18'(2 * m_idx + 1)} : 36'hA5A5A5A5A;
    end

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return 32'(vga_flag);
            1:       return 32'(pixel_out);
            2:       return 32'(underflow);
            3:       return 32'(underflow_sticky);
            default: return 32'(flag2);
        endcase
    endfunction

    function automatic string sname(input int sel);
        case (sel)
            0:       return "vga_flag";
            1:       return "pixel_out";
            2:       return "underflow";
            3:       return "underflow_sticky";
            default: return "small_vga_flag";
        endcase
    endfunction

    chk_t        mc;
    logic [31:0] mact;
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mc   = q.pop_front();
            mact = actual(mc.sel);
            n_checks++;
            if (mact !== mc.exp) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got %0d expected %0d", sname(mc.sel), mc.cyc, mact, mc.exp);
            end
        end
        if (timeout_hit && q.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain cyc=%0d got %0d pending expected 0", cyc, q.size());
            q.delete();
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input int sel, input int dly, input logic [31:0] e);
        chk_t c;
        c.cyc = cyc + dly;
        c.sel = sel;
        c.exp = e;
        q.push_back(c);
    endtask

    task automatic chk_all_zero();
        chk(0, 0, 0);
        chk(1, 0, 0);
        chk(2, 0, 0);
        chk(3, 0, 0);
    endtask

    // Frame start from IDLE with continuous grants: exactly 8 requests fill the FIFO.
    task automatic fill_frame();
        tick();
        frame_flag = 1'b1;
        done_vga   = 1'b1;
        blank      = 1'b1;
        gbase      = gcnt;
        chk(0, 0, 0);
        for (int i = 1; i < 12; i++) begin
            tick();
            frame_flag = 1'b0;
            chk(0, 0, (i <= 8) ? 32'd1 : 32'd0);
        end
    endtask

    // One active line segment: 16 columns from 8 buffered words, then 4 starved columns.
    task automatic display();
        for (int h = 0; h < 20; h++) begin
            tick();
            done_vga = 1'b0;
            blank    = 1'b0;
            vcount   = '0;
            hcount   = 11'(h);
            chk(1, 1, (h < 16) ? 32'(h) : 32'd0);
            chk(2, 1, (h >= 16) ? 32'd1 : 32'd0);
            if (h == 0) chk(3, 1, 0);
        end
        tick();
        blank  = 1'b1;
        hcount = '0;
        chk(1, 1, 0);
        chk(2, 1, 0);
        chk(3, 1, 1);
    endtask

    initial begin
        repeat (3) begin
            tick();
            chk_all_zero();
        end
        tick();
        reset = 1'b1;

        fill_frame();
        display();

        // Reset with two reads in flight; their returns must never reach the FIFO.
        tick();
        blank    = 1'b1;
        done_vga = 1'b1;
        chk(0, 0, 1);
        chk(3, 0, 1);
        tick();
        tick();
        reset    = 1'b0;
        done_vga = 1'b0;
        chk_all_zero();
        repeat (3) begin
            tick();
            chk_all_zero();
        end
        tick();
        reset = 1'b1;

        fill_frame();
        display();

        // Two grants, then frame_flag with a coinciding grant that becomes word 0.
        tick();
        blank    = 1'b1;
        done_vga = 1'b1;
        chk(3, 0, 1);
        tick();
        tick();
        frame_flag = 1'b1;
        gbase      = gcnt;
        tick();
        frame_flag = 1'b0;
        chk(3, 0, 0);
        repeat (14) tick();
        done_vga = 1'b0;
        display();

        // Small image: 4 words per frame, then DONE until the next frame_flag.
        tick();
        ff2 = 1'b1;
        chk(4, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            ff2 = 1'b0;
            chk(4, 0, (i <= 4) ? 32'd1 : 32'd0);
        end
        tick();
        ff2 = 1'b1;
        chk(4, 0, 0);
        tick();
        ff2 = 1'b0;
        chk(4, 0, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) timeout_hit = 1'b1;
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
